// File: rtl/gba_cart_bus_ctrl_pkg.sv
// gba_cart_pkg: shared types and helpers for the GBA cartridge bus controller.
//   cmd_op_e   - host operation code (ROM/SRAM, read/write)
//   state_e    - bus sequencer states
//   pins_t     - registered cartridge control pins plus AD lane enables
//   decode_pins- maps (state, op) to the pin levels that state must present
package gba_cart_pkg;

  localparam int          CART_ADDR_W = 24;
  localparam logic [15:0] WRAP_MASK   = 16'hFFFF;

  typedef enum logic [1:0] {
    ROM_RD  = 2'b00,
    ROM_WR  = 2'b01,
    SRAM_RD = 2'b10,
    SRAM_WR = 2'b11
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_LATCH  = 3'd2,
    ST_STROBE = 3'd3,
    ST_RECOV  = 3'd4,
    ST_END    = 3'd5
  } state_e;

  typedef struct packed {
    logic       ncs;
    logic       ncs2;
    logic       nrd;
    logic       nwr;
    logic [2:0] oe;    // lane enables: [0]=AD[7:0], [1]=AD[15:8], [2]=AD[23:16]
  } pins_t;

  localparam pins_t PINS_IDLE = '{ncs: 1'b1, ncs2: 1'b1, nrd: 1'b1, nwr: 1'b1, oe: 3'b000};

  function automatic logic op_is_sram(input cmd_op_e op);
    return (op == SRAM_RD) || (op == SRAM_WR);
  endfunction

  function automatic logic op_is_wr(input cmd_op_e op);
    return (op == ROM_WR) || (op == SRAM_WR);
  endfunction

  function automatic pins_t decode_pins(input state_e st, input cmd_op_e op);
    pins_t      p;
    logic [2:0] data_oe;
    p = PINS_IDLE;
    // Writes keep every lane driven; ROM reads hand the whole bus to the
    // cart; SRAM reads only give up the upper lane where the byte returns.
    if (op_is_wr(op)) begin
      data_oe = 3'b111;
    end else if (op_is_sram(op)) begin
      data_oe = 3'b011;
    end else begin
      data_oe = 3'b000;
    end
    case (st)
      ST_ADDR: begin
        p.oe = 3'b111;
      end
      ST_LATCH: begin
        p.oe   = 3'b111;
        p.ncs  = op_is_sram(op);
        p.ncs2 = !op_is_sram(op);
      end
      ST_STROBE: begin
        p.oe   = data_oe;
        p.ncs  = op_is_sram(op);
        p.ncs2 = !op_is_sram(op);
        p.nrd  = op_is_wr(op);
        p.nwr  = !op_is_wr(op);
      end
      ST_RECOV: begin
        p.oe   = data_oe;
        p.ncs  = op_is_sram(op);
        p.ncs2 = !op_is_sram(op);
      end
      default: begin
        p = PINS_IDLE;
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/gba_cart_bus_ctrl_if.sv
// gba_cart_bus_ctrl_if: host-side command / read-data bundle.
//   master: host (drives cmd_*), slave: controller (drives cmd_ready, rd_*, busy)
interface gba_cart_bus_ctrl_if #(
  parameter int ADDR_W = gba_cart_pkg::CART_ADDR_W,
  parameter int LEN_W  = 8
);
  import gba_cart_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  cmd_op_e           cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [15:0]       cmd_wdata;
  logic              rd_valid;
  logic [15:0]       rd_data;
  logic              rd_last;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata,
    input  cmd_ready, rd_valid, rd_data, rd_last, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_wdata,
    output cmd_ready, rd_valid, rd_data, rd_last, busy
  );
endinterface

// File: rtl/gba_cart_bus_ctrl_cart_ad_pad.sv
// cart_ad_pad: byte-lane tristate for the 24-bit cartridge AD bus.
//   dout - value to drive, oe - per-lane enables ([0]=7:0, [1]=15:8, [2]=23:16)
//   din  - read-back of the pad, pad - the shared AD bus
module cart_ad_pad (
  input  logic [23:0] dout,
  input  logic [2:0]  oe,
  output logic [23:0] din,
  inout  wire  [23:0] pad
);
  assign pad[7:0]   = oe[0] ? dout[7:0]   : 8'hzz;
  assign pad[15:8]  = oe[1] ? dout[15:8]  : 8'hzz;
  assign pad[23:16] = oe[2] ? dout[23:16] : 8'hzz;
  assign din        = pad;
endmodule

// File: rtl/gba_cart_bus_ctrl.sv
// gba_cart_bus_ctrl: sequences complete ROM/SRAM cycles on the GBA cart edge.
//   clk, rst       - system clock, synchronous active-high reset
//   bus (slave)    - command handshake, read data stream, busy
//   cart_clk       - cartridge clock pin, held low
//   nCS/nCS2/nRD/nWR - active-low cartridge control pins (registered)
//   add_dat_inout  - multiplexed AD bus
// ROM reads of more than one word use the cart's internal address
// auto-increment; crossing a 64K-halfword boundary forces a fresh address
// latch because the cart only increments the low 16 bits.
module gba_cart_bus_ctrl #(
  parameter int ADDR_W       = gba_cart_pkg::CART_ADDR_W,
  parameter int SETUP_CYCLES = 1,
  parameter int WAIT_CYCLES  = 3,
  parameter int LEN_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  gba_cart_bus_ctrl_if.slave  bus,
  output logic                cart_clk,
  output logic                nCS,
  output logic                nCS2,
  output logic                nRD,
  output logic                nWR,
  inout  wire  [23:0]         add_dat_inout
);
  import gba_cart_pkg::*;

  localparam int MAX_CYC = (SETUP_CYCLES > WAIT_CYCLES) ? SETUP_CYCLES : WAIT_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC) + 1;
  localparam logic [TMR_W-1:0]  SETUP_LD  = TMR_W'(SETUP_CYCLES - 1);
  localparam logic [TMR_W-1:0]  WAIT_LD   = TMR_W'(WAIT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ZERO  = {TMR_W{1'b0}};
  localparam logic [LEN_W:0]    WORDS_ZERO = {(LEN_W+1){1'b0}};

  state_e            state_r, state_s;
  cmd_op_e           op_r, op_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [15:0]       wdata_r, wdata_s;
  logic [LEN_W:0]    words_r, words_s;   // words still to read after the current one
  logic [TMR_W-1:0]  tmr_r, tmr_s;
  logic              wrap_r, wrap_s;     // END must re-latch rather than go idle
  logic              sample_s;
  logic              handshake_s;
  pins_t             pins_r;
  logic [23:0]       ad_out_r;
  logic [23:0]       ad_in_s;
  logic [2:0]        ad_oe_s;
  logic              busy_r;
  logic              rd_valid_r;
  logic [15:0]       rd_data_r;
  logic              rd_last_r;

  // Value presented on AD for a given state; SRAM keeps the byte address on
  // the low lanes and write data on the top lane for the whole access.
  function automatic logic [23:0] ad_word(input state_e st, input cmd_op_e op,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [15:0] wdata);
    logic [23:0] w;
    w = 24'h000000;
    if (op == SRAM_WR) begin
      w = {wdata[7:0], addr[15:0]};
    end else if (op == SRAM_RD) begin
      w = {8'h00, addr[15:0]};
    end else if ((st == ST_ADDR) || (st == ST_LATCH)) begin
      w = 24'(addr);
    end else begin
      w = {8'h00, wdata};
    end
    return w;
  endfunction

  assign bus.cmd_ready = (state_r == ST_IDLE) && !rst;
  assign handshake_s   = bus.cmd_valid && bus.cmd_ready;

  // Next-state, counters and command capture.
  always_comb begin
    state_s  = state_r;
    op_s     = op_r;
    addr_s   = addr_r;
    wdata_s  = wdata_r;
    words_s  = words_r;
    tmr_s    = tmr_r;
    wrap_s   = wrap_r;
    sample_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (handshake_s) begin
          state_s = ST_ADDR;
          op_s    = bus.cmd_op;
          addr_s  = bus.cmd_addr;
          wdata_s = bus.cmd_wdata;
          words_s = (bus.cmd_op == ROM_RD) ? {1'b0, bus.cmd_len} : WORDS_ZERO;
          tmr_s   = SETUP_LD;
          wrap_s  = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (tmr_r == TMR_ZERO) begin
          state_s = ST_LATCH;
        end else begin
          tmr_s = tmr_r - TMR_W'(1);
        end
      end
      ST_LATCH: begin
        state_s = ST_STROBE;
        tmr_s   = WAIT_LD;
      end
      ST_STROBE: begin
        if (tmr_r == TMR_ZERO) begin
          state_s  = ST_RECOV;
          sample_s = !op_is_wr(op_r);
        end else begin
          tmr_s = tmr_r - TMR_W'(1);
        end
      end
      ST_RECOV: begin
        addr_s = addr_r + ADDR_W'(1);
        if (words_r != WORDS_ZERO) begin
          words_s = words_r - (LEN_W+1)'(1);
          // The cart's auto-increment does not carry into bits [23:16].
          if (addr_r[15:0] == WRAP_MASK) begin
            state_s = ST_END;
            wrap_s  = 1'b1;
          end else begin
            state_s = ST_STROBE;
            tmr_s   = WAIT_LD;
          end
        end else begin
          state_s = ST_END;
        end
      end
      ST_END: begin
        if (wrap_r) begin
          state_s = ST_ADDR;
          wrap_s  = 1'b0;
          tmr_s   = SETUP_LD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, pin/bus output registers and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      op_r       <= ROM_RD;
      addr_r     <= {ADDR_W{1'b0}};
      wdata_r    <= 16'h0000;
      words_r    <= WORDS_ZERO;
      tmr_r      <= TMR_ZERO;
      wrap_r     <= 1'b0;
      pins_r     <= PINS_IDLE;
      ad_out_r   <= 24'h000000;
      busy_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= 16'h0000;
      rd_last_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      op_r       <= op_s;
      addr_r     <= addr_s;
      wdata_r    <= wdata_s;
      words_r    <= words_s;
      tmr_r      <= tmr_s;
      wrap_r     <= wrap_s;
      // Pins are decoded from the next state so they line up with state_r.
      pins_r     <= decode_pins(state_s, op_s);
      ad_out_r   <= ad_word(state_s, op_s, addr_s, wdata_s);
      busy_r     <= (state_s != ST_IDLE);
      rd_valid_r <= sample_s;
      rd_last_r  <= sample_s && (words_r == WORDS_ZERO);
      if (sample_s) begin
        rd_data_r <= op_is_sram(op_r) ? {8'h00, ad_in_s[23:16]} : ad_in_s[15:0];
      end
    end
  end

  assign ad_oe_s = pins_r.oe;

  cart_ad_pad u_pad (
    .dout (ad_out_r),
    .oe   (ad_oe_s),
    .din  (ad_in_s),
    .pad  (add_dat_inout)
  );

  assign nCS          = pins_r.ncs;
  assign nCS2         = pins_r.ncs2;
  assign nRD          = pins_r.nrd;
  assign nWR          = pins_r.nwr;
  assign cart_clk     = 1'b0;
  assign bus.busy     = busy_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.rd_data  = rd_data_r;
  assign bus.rd_last  = rd_last_r;

endmodule

// File: tb/tb_gba_cart_bus_ctrl.sv
// tb_gba_cart_bus_ctrl: directed bench for gba_cart_bus_ctrl with a small
// behavioural cartridge (auto-incrementing ROM, byte-wide SRAM) on the AD bus.
module tb_gba_cart_bus_ctrl;
  import gba_cart_pkg::*;

  typedef struct packed {
    logic ncs; logic ncs2; logic nrd; logic nwr;
    logic rv;  logic rl;   logic rdy; logic busy;
  } tr_t;

  typedef struct {
    cmd_op_e     op;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic        is_rd;
    logic [15:0] exp_data;
  } cmd_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cart_clk, nCS, nCS2, nRD, nWR;
  wire  [23:0] ad;

  always #5 clk = ~clk;

  gba_cart_bus_ctrl_if #(.ADDR_W(24), .LEN_W(8)) bus ();

  gba_cart_bus_ctrl #(.ADDR_W(24), .SETUP_CYCLES(1), .WAIT_CYCLES(3), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cart_clk(cart_clk),
    .nCS(nCS), .nCS2(nCS2), .nRD(nRD), .nWR(nWR), .add_dat_inout(ad)
  );

  // ---------------- cartridge model ----------------
  function automatic logic [15:0] rom_word(input logic [23:0] a);
    return a[15:0] ^ 16'hA4A5;
  endfunction

  logic [23:0] rom_addr  = 24'h000000;
  logic [15:0] sram_addr = 16'h0000;
  logic [7:0]  sram_mem [0:65535];

  always @(negedge nCS)  rom_addr <= ad;
  always @(posedge nRD)  if (!nCS) rom_addr <= rom_addr + 24'd1;
  always @(negedge nCS2) sram_addr <= ad[15:0];
  always @(posedge nWR)  if (!nCS2) sram_mem[sram_addr] <= ad[23:16];

  assign ad[15:0]  = (!nCS && !nRD)  ? rom_word(rom_addr)  : 16'hzzzz;
  assign ad[23:16] = (!nCS2 && !nRD) ? sram_mem[sram_addr] : 8'hzz;

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  tr_t         trace [0:63];
  logic [15:0] got_data [$];
  logic        got_last [$];
  int          got_cyc  [$];
  logic [23:0] addr_ph  [$];
  int nrd_low, nwr_low, ncs_low, ncs2_low, wr_bad, z_bad, done_cyc;

  function automatic tr_t sample();
    return '{ncs: nCS, ncs2: nCS2, nrd: nRD, nwr: nWR, rv: bus.rd_valid,
             rl: bus.rd_last, rdy: bus.cmd_ready, busy: bus.busy};
  endfunction

  // Issue one command and log pins/data per cycle until cmd_ready returns.
  task automatic run_cmd(input cmd_op_e op, input logic [23:0] a,
                         input logic [7:0] len, input logic [15:0] wd);
    int          w;
    logic [23:0] exp_ad;
    got_data.delete(); got_last.delete(); got_cyc.delete(); addr_ph.delete();
    nrd_low = 0; nwr_low = 0; ncs_low = 0; ncs2_low = 0; wr_bad = 0; z_bad = 0;
    done_cyc = -1;
    w = 0;
    @(negedge clk);
    while (!bus.cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) begin
      n_chk++; n_fail++;
      $display("FAIL ready_wait: cmd_ready 0 after %0d cycles, expected 1", w);
    end
    trace[0] = sample();
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = a;
    bus.cmd_len = len; bus.cmd_wdata = wd;
    exp_ad = (op == SRAM_WR) ? {wd[7:0], a[15:0]} : {8'h00, wd};
    for (int k = 1; k < 64; k++) begin
      @(negedge clk);
      trace[k] = sample();
      bus.cmd_valid = 1'b0;
      if (!nCS)  ncs_low++;
      if (!nCS2) ncs2_low++;
      if (!nRD) begin
        nrd_low++;
        if ((op == SRAM_RD) ? dut.ad_oe_s[2] : (dut.ad_oe_s != 3'b000)) z_bad++;
      end
      if (!nWR) begin
        nwr_low++;
        if (ad !== exp_ad) wr_bad++;
      end
      if (bus.busy && nCS && nCS2 && nRD && nWR && dut.ad_oe_s == 3'b111)
        addr_ph.push_back(ad);
      if (bus.rd_valid) begin
        got_data.push_back(bus.rd_data);
        got_last.push_back(bus.rd_last);
        got_cyc.push_back(k);
      end
      if (bus.cmd_ready) begin
        done_cyc = k;
        break;
      end
    end
    if (done_cyc < 0) begin
      n_chk++; n_fail++;
      $display("FAIL cmd_timeout: cmd_ready not back within 63 cycles, expected return");
    end
  endtask

  tr_t      exp_tr [0:8];
  cmd_vec_t vecs   [0:7];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rv_cnt, busy_cnt;
    logic [15:0] first_d;
    int          rv_cyc [$];
    int          exp_cyc [0:3];

    // Expected pin trace of a single ROM read: {nCS,nCS2,nRD,nWR,rv,rl,rdy,busy}
    exp_tr[0] = 8'b1111_0010;   // handshake, IDLE
    exp_tr[1] = 8'b1111_0001;   // ADDR
    exp_tr[2] = 8'b0111_0001;   // LATCH
    exp_tr[3] = 8'b0101_0001;   // STROBE
    exp_tr[4] = 8'b0101_0001;
    exp_tr[5] = 8'b0101_0001;
    exp_tr[6] = 8'b0111_1101;   // RECOV with data
    exp_tr[7] = 8'b1111_0001;   // END
    exp_tr[8] = 8'b1111_0010;   // IDLE again

    vecs[0] = '{SRAM_WR, 24'h001234, 16'hAB5C, 1'b0, 16'h0000};
    vecs[1] = '{SRAM_RD, 24'h001234, 16'h0000, 1'b1, 16'h005C};
    vecs[2] = '{ROM_WR,  24'h0000AA, 16'hBEEF, 1'b0, 16'h0000};
    vecs[3] = '{ROM_RD,  24'h000100, 16'h0000, 1'b1, 16'hA5A5};
    vecs[4] = '{ROM_RD,  24'h123456, 16'h0000, 1'b1, 16'h90F3};
    vecs[5] = '{SRAM_WR, 24'h0000FF, 16'h003C, 1'b0, 16'h0000};
    vecs[6] = '{SRAM_RD, 24'h0000FF, 16'h0000, 1'b1, 16'h003C};
    vecs[7] = '{SRAM_RD, 24'h001234, 16'h0000, 1'b1, 16'h005C};

    bus.cmd_valid = 1'b0; bus.cmd_op = ROM_RD; bus.cmd_addr = 24'h000000;
    bus.cmd_len = 8'd0; bus.cmd_wdata = 16'h0000;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_pins", 32'({nCS, nCS2, nRD, nWR}), 32'hF);
    chk("rst_oe", 32'(dut.ad_oe_s), 32'h0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_rd", 32'({bus.rd_valid, bus.rd_last, bus.rd_data}), 32'h0);
    chk("rst_cart_clk", 32'(cart_clk), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(bus.cmd_ready), 32'h1);

    // Single-access table
    for (int i = 0; i < 8; i++) begin
      logic is_sram;
      is_sram = (vecs[i].op == SRAM_RD) || (vecs[i].op == SRAM_WR);
      run_cmd(vecs[i].op, vecs[i].addr, 8'd0, vecs[i].wdata);
      chk($sformatf("v%0d_done_cyc", i), 32'(done_cyc), 32'd8);
      chk($sformatf("v%0d_nrd_low", i), 32'(nrd_low), vecs[i].is_rd ? 32'd3 : 32'd0);
      chk($sformatf("v%0d_nwr_low", i), 32'(nwr_low), vecs[i].is_rd ? 32'd0 : 32'd3);
      chk($sformatf("v%0d_ncs_low", i), 32'(ncs_low), is_sram ? 32'd0 : 32'd5);
      chk($sformatf("v%0d_ncs2_low", i), 32'(ncs2_low), is_sram ? 32'd5 : 32'd0);
      chk($sformatf("v%0d_wr_bus", i), 32'(wr_bad), 32'd0);
      chk($sformatf("v%0d_rd_release", i), 32'(z_bad), 32'd0);
      chk($sformatf("v%0d_n_words", i), 32'(got_data.size()), vecs[i].is_rd ? 32'd1 : 32'd0);
      if (got_data.size() > 0) begin
        chk($sformatf("v%0d_data", i), 32'(got_data[0]), 32'(vecs[i].exp_data));
        chk($sformatf("v%0d_last", i), 32'(got_last[0]), 32'd1);
        chk($sformatf("v%0d_rv_cyc", i), 32'(got_cyc[0]), 32'd6);
      end
      chk($sformatf("v%0d_n_addr_ph", i), 32'(addr_ph.size()), 32'd1);
      if (addr_ph.size() > 0)
        chk($sformatf("v%0d_addr_ph", i),
            is_sram ? 32'(addr_ph[0][15:0]) : 32'(addr_ph[0]),
            is_sram ? 32'(vecs[i].addr[15:0]) : 32'(vecs[i].addr));
      if (vecs[i].op == ROM_RD && vecs[i].addr == 24'h000100)
        for (int k = 0; k < 9; k++)
          chk($sformatf("trace_c%0d", k), 32'(trace[k]), 32'(exp_tr[k]));
    end

    // Burst across a 64K-halfword boundary
    exp_cyc[0] = 6; exp_cyc[1] = 10; exp_cyc[2] = 17; exp_cyc[3] = 21;
    run_cmd(ROM_RD, 24'h00FFFE, 8'd3, 16'h0000);
    chk("burst_n_words", 32'(got_data.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_data.size()) begin
        chk($sformatf("burst_w%0d_data", i), 32'(got_data[i]), 32'(rom_word(24'h00FFFE + 24'(i))));
        chk($sformatf("burst_w%0d_cyc", i), 32'(got_cyc[i]), 32'(exp_cyc[i]));
        chk($sformatf("burst_w%0d_last", i), 32'(got_last[i]), (i == 3) ? 32'd1 : 32'd0);
      end
    end
    chk("burst_n_addr_ph", 32'(addr_ph.size()), 32'd2);
    if (addr_ph.size() == 2) begin
      chk("burst_addr_ph0", 32'(addr_ph[0]), 32'h00FFFE);
      chk("burst_addr_ph1", 32'(addr_ph[1]), 32'h010000);
    end
    chk("burst_done_cyc", 32'(done_cyc), 32'd23);

    // Reset during the second word of a len-7 burst
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = ROM_RD; bus.cmd_addr = 24'h000200;
    bus.cmd_len = 8'd7; bus.cmd_wdata = 16'h0000;
    rv_cnt = 0; first_d = 16'h0000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.rd_valid) begin
        rv_cnt++;
        first_d = bus.rd_data;
      end
    end
    chk("rstmid_in_strobe", 32'(nRD), 32'h0);
    chk("rstmid_words_before", 32'(rv_cnt), 32'd1);
    chk("rstmid_first_data", 32'(first_d), 32'hA6A5);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_pins", 32'({nCS, nCS2, nRD, nWR}), 32'hF);
    chk("rstmid_oe", 32'(dut.ad_oe_s), 32'h0);
    chk("rstmid_busy", 32'(bus.busy), 32'h0);
    chk("rstmid_ready", 32'(bus.cmd_ready), 32'h0);
    chk("rstmid_rv", 32'(bus.rd_valid), 32'h0);
    rst = 1'b0;
    rv_cnt = 0; busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rd_valid) rv_cnt++;
      if (bus.busy) busy_cnt++;
    end
    chk("rstmid_no_more_rv", 32'(rv_cnt), 32'd0);
    chk("rstmid_stays_idle", 32'(busy_cnt), 32'd0);
    chk("rstmid_ready_back", 32'(bus.cmd_ready), 32'h1);

    // cmd_valid held through busy: one acceptance per IDLE visit
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = ROM_RD; bus.cmd_addr = 24'h000100;
    bus.cmd_len = 8'd0;
    busy_cnt = 0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (bus.rd_valid) rv_cyc.push_back(k);
      if (k >= 17 && bus.busy) busy_cnt++;
      if (k == 9) bus.cmd_valid = 1'b0;
    end
    chk("hold_n_words", 32'(rv_cyc.size()), 32'd2);
    if (rv_cyc.size() == 2) begin
      chk("hold_rv0_cyc", 32'(rv_cyc[0]), 32'd6);
      chk("hold_rv1_cyc", 32'(rv_cyc[1]), 32'd14);
    end
    chk("hold_idle_after", 32'(busy_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
